// File: rtl/riscv_pkg.sv
//------------------------------------------------------------------------------
// Module : riscv_pkg
// Brief  : Shared ALU opcode and forward-select constants for the RV32I core.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

`default_nettype wire

// File: rtl/iexecute_alu.sv
//------------------------------------------------------------------------------
// Module : alu
// Brief  : Combinational RV32I execute ALU (add/sub/and/or/slt) with zero flag.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu
   import riscv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   input  logic [2:0]      ALUControl,
   output logic [XLEN-1:0] ALUResult,
   output logic            Zero
);

   always_comb begin
      ALUResult = '0;
      case (ALUControl)
         ALU_ADD: ALUResult = SrcA + SrcB;
         ALU_SUB: ALUResult = SrcA - SrcB;
         ALU_AND: ALUResult = SrcA & SrcB;
         ALU_OR:  ALUResult = SrcA | SrcB;
         ALU_SLT: ALUResult = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         default: ALUResult = '0;
      endcase
   end

   assign Zero = (ALUResult == '0);

endmodule

`default_nettype wire

// File: rtl/iexecute.sv
//------------------------------------------------------------------------------
// Module : iexecute
// Brief  : RV32I execute stage with EX/MEM register; IEXECUTE_FWD_EN enables
//          operand forwarding muxes.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module iexecute
   import riscv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             StallM,
   input  logic             FlushM,
   input  logic             RegWriteE,
   input  logic             MemWriteE,
   input  logic             JumpE,
   input  logic             BranchE,
   input  logic             ALUSrcE,
   input  logic [1:0]       ResultSrcE,
   input  logic [2:0]       ALUControlE,
   input  logic [4:0]       RdE,
   input  logic [XLEN-1:0]  RD1E,
   input  logic [XLEN-1:0]  RD2E,
   input  logic [XLEN-1:0]  PCE,
   input  logic [XLEN-1:0]  ImmExtE,
   input  logic [XLEN-1:0]  PCPlus4E,
   input  logic [1:0]       ForwardAE,
   input  logic [1:0]       ForwardBE,
   input  logic [XLEN-1:0]  ResultW,
   output logic             PCSrcE,
   output logic [XLEN-1:0]  PCTargetE,
   output logic             RegWriteM,
   output logic             MemWriteM,
   output logic [1:0]       ResultSrcM,
   output logic [4:0]       RdM,
   output logic [XLEN-1:0]  ALUResultM,
   output logic [XLEN-1:0]  WriteDataM,
   output logic [XLEN-1:0]  PCPlus4M,
   output logic [CNT_W-1:0] RedirectCnt
);

   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] write_data;
   logic [XLEN-1:0] alu_result;
   logic            zero;

`ifdef IEXECUTE_FWD_EN
   // Forward path 10 takes the instruction one ahead, already in EX/MEM.
   always_comb begin
      src_a = RD1E;
      case (ForwardAE)
         FWD_WB:  src_a = ResultW;
         FWD_MEM: src_a = ALUResultM;
         default: src_a = RD1E;
      endcase
   end

   always_comb begin
      write_data = RD2E;
      case (ForwardBE)
         FWD_WB:  write_data = ResultW;
         FWD_MEM: write_data = ALUResultM;
         default: write_data = RD2E;
      endcase
   end
`else
   // Hazards are resolved by upstream stalls; forward inputs kept for the interface.
   assign src_a      = RD1E;
   assign write_data = RD2E;
   logic unused_fwd;
   assign unused_fwd = ^{ForwardAE, ForwardBE, ResultW};
`endif

   assign src_b = ALUSrcE ? ImmExtE : write_data;

   alu #(.XLEN(XLEN)) u_alu (
      .SrcA       (src_a),
      .SrcB       (src_b),
      .ALUControl (ALUControlE),
      .ALUResult  (alu_result),
      .Zero       (zero)
   );

   assign PCTargetE = PCE + ImmExtE;
   assign PCSrcE    = JumpE | (BranchE & zero);

   // Flush beats stall; the redirect counter ignores stall but not flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         RegWriteM   <= 1'b0;
         MemWriteM   <= 1'b0;
         ResultSrcM  <= '0;
         RdM         <= '0;
         ALUResultM  <= '0;
         WriteDataM  <= '0;
         PCPlus4M    <= '0;
         RedirectCnt <= '0;
      end else begin
         if (FlushM) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            RdM        <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
         end else if (!StallM) begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RdM        <= RdE;
            ALUResultM <= alu_result;
            WriteDataM <= write_data;
            PCPlus4M   <= PCPlus4E;
         end
         if (PCSrcE && !FlushM)
            RedirectCnt <= RedirectCnt + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_iexecute.sv
//------------------------------------------------------------------------------
// Module : tb_iexecute
// Brief  : Directed vector bench for the iexecute stage.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_iexecute;

   logic        clk = 1'b0;
   logic        reset;
   logic        StallM, FlushM, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
   logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
   logic [2:0]  ALUControlE;
   logic [4:0]  RdE;
   logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
   logic        PCSrcE, RegWriteM, MemWriteM;
   logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M, RedirectCnt;
   logic [1:0]  ResultSrcM;
   logic [4:0]  RdM;

   int          nvec = 0;
   int          nerr = 0;
   logic [31:0] cnt_exp = 32'd0;

   always #5 clk = ~clk;

   iexecute dut (
      .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
      .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RdE(RdE),
      .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
      .ResultSrcM(ResultSrcM), .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .PCPlus4M(PCPlus4M), .RedirectCnt(RedirectCnt)
   );

   typedef struct {
      logic        alusrc;
      logic [2:0]  ctl;
      logic        branch;
      logic        jump;
      logic        regwr;
      logic        memwr;
      logic [1:0]  rsrc;
      logic [4:0]  rd;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        exp_pcsrc;
      logic [31:0] exp_target;
      logic [31:0] exp_alu;
      logic [31:0] exp_wd;
   } vec_t;

   vec_t vt[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      ALUSrcE     = v.alusrc;
      ALUControlE = v.ctl;
      BranchE     = v.branch;
      JumpE       = v.jump;
      RegWriteE   = v.regwr;
      MemWriteE   = v.memwr;
      ResultSrcE  = v.rsrc;
      RdE         = v.rd;
      RD1E        = v.rd1;
      RD2E        = v.rd2;
      ImmExtE     = v.imm;
      PCE         = v.pc;
      PCPlus4E    = v.pc + 32'd4;
   endtask

   function automatic vec_t mk(logic alusrc, logic [2:0] ctl, logic br, logic jp,
                               logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm,
                               logic [31:0] pc, logic pcs, logic [31:0] alu);
      vec_t v;
      v.alusrc = alusrc; v.ctl = ctl; v.branch = br; v.jump = jp;
      v.regwr = rd1[0]; v.memwr = rd2[0]; v.rsrc = rd1[1:0] ^ 2'b10; v.rd = rd1[4:0] ^ 5'h11;
      v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.pc = pc;
      v.exp_pcsrc = pcs; v.exp_target = pc + imm; v.exp_alu = alu; v.exp_wd = rd2;
      return v;
   endfunction

   initial begin
      vt[0]  = mk(0, 3'b000, 0, 0, 32'd5, 32'd3, 32'd0, 32'h0, 0, 32'd8);
      vt[1]  = mk(0, 3'b001, 0, 0, 32'd5, 32'd3, 32'd0, 32'h0, 0, 32'd2);
      vt[2]  = mk(1, 3'b101, 0, 0, 32'hFFFF_FFFF, 32'd9, 32'd1, 32'h40, 0, 32'd1);
      vt[3]  = mk(0, 3'b001, 1, 0, 32'd7, 32'd7, 32'hFFFF_FFF0, 32'h100, 1, 32'd0);
      vt[4]  = mk(0, 3'b001, 1, 0, 32'd7, 32'd8, 32'hFFFF_FFF0, 32'h100, 0, 32'hFFFF_FFFF);
      vt[5]  = mk(0, 3'b010, 0, 0, 32'h0000_F0F0, 32'h0000_0FF0, 32'd4, 32'h200, 0, 32'h0000_00F0);
      vt[6]  = mk(0, 3'b011, 0, 0, 32'h0000_F000, 32'h0000_000F, 32'd4, 32'h200, 0, 32'h0000_F00F);
      vt[7]  = mk(0, 3'b000, 0, 1, 32'd1, 32'd2, 32'd8, 32'h1000, 1, 32'd3);
      vt[8]  = mk(0, 3'b100, 1, 0, 32'd6, 32'd1, 32'd12, 32'h300, 1, 32'd0);
      vt[9]  = mk(1, 3'b000, 0, 0, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFC, 0, 32'd0);
      vt[10] = mk(0, 3'b101, 0, 0, 32'd5, 32'hFFFF_FFFD, 32'd0, 32'h10, 0, 32'd0);
      vt[11] = mk(0, 3'b111, 0, 0, 32'd5, 32'd5, 32'd0, 32'h20, 0, 32'd0);

      reset = 1'b0; StallM = 1'b0; FlushM = 1'b0;
      ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 32'd0;
      drive(vt[0]);
      #12;
      check("reset ALUResultM", ALUResultM, 32'd0);
      check("reset ctrl", {27'd0, RegWriteM, MemWriteM, ResultSrcM, 1'b0}, 32'd0);
      check("reset RedirectCnt", RedirectCnt, 32'd0);
      @(negedge clk); reset = 1'b1;

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(vt[i]);
         #1;
         check($sformatf("v%0d PCSrcE", i), {31'd0, PCSrcE}, {31'd0, vt[i].exp_pcsrc});
         check($sformatf("v%0d PCTargetE", i), PCTargetE, vt[i].exp_target);
         if (vt[i].exp_pcsrc) cnt_exp = cnt_exp + 32'd1;
         @(posedge clk); #1;
         check($sformatf("v%0d ALUResultM", i), ALUResultM, vt[i].exp_alu);
         check($sformatf("v%0d WriteDataM", i), WriteDataM, vt[i].exp_wd);
         check($sformatf("v%0d ctrlM", i), {23'd0, RegWriteM, MemWriteM, ResultSrcM, RdM},
               {23'd0, vt[i].regwr, vt[i].memwr, vt[i].rsrc, vt[i].rd});
         check($sformatf("v%0d PCPlus4M", i), PCPlus4M, vt[i].pc + 32'd4);
         check($sformatf("v%0d RedirectCnt", i), RedirectCnt, cnt_exp);
      end

      // Forwarding: seed ALUResultM = 0x20, then forward MEM into A and WB into B.
      @(negedge clk);
      drive(mk(0, 3'b000, 0, 0, 32'h10, 32'h10, 32'd0, 32'h0, 0, 32'h20));
      @(posedge clk); #1;
      check("fwd seed ALUResultM", ALUResultM, 32'h20);
      @(negedge clk);
      drive(mk(0, 3'b000, 0, 0, 32'd1, 32'd2, 32'd0, 32'h0, 0, 32'd3));
      ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h30;
      @(posedge clk); #1;
`ifdef IEXECUTE_FWD_EN
      check("fwd ALUResultM", ALUResultM, 32'h50);
      check("fwd WriteDataM", WriteDataM, 32'h30);
`else
      check("fwd ALUResultM", ALUResultM, 32'd3);
      check("fwd WriteDataM", WriteDataM, 32'd2);
`endif
      ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 32'd0;

      // Stall two cycles with a jump active: M holds, counter still advances.
      @(negedge clk);
      drive(mk(0, 3'b000, 0, 0, 32'd9, 32'd9, 32'd0, 32'h500, 0, 32'd18));
      @(posedge clk); #1;
      check("pre-stall ALUResultM", ALUResultM, 32'd18);
      @(negedge clk);
      drive(mk(0, 3'b001, 0, 1, 32'd100, 32'd1, 32'd4, 32'h600, 1, 32'd99));
      StallM = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         cnt_exp = cnt_exp + 32'd1;
         check("stall ALUResultM", ALUResultM, 32'd18);
         check("stall PCPlus4M", PCPlus4M, 32'h504);
         check("stall RedirectCnt", RedirectCnt, cnt_exp);
      end

      // Flush together with stall: bubble wins, redirect not counted.
      @(negedge clk); FlushM = 1'b1;
      @(posedge clk); #1;
      check("flush ctrl", {23'd0, RegWriteM, MemWriteM, ResultSrcM, RdM}, 32'd0);
      check("flush ALUResultM", ALUResultM, 32'd0);
      check("flush RedirectCnt", RedirectCnt, cnt_exp);
      @(negedge clk); FlushM = 1'b0; StallM = 1'b0;

      // Async reset mid-cycle with MemWriteM set.
      drive(mk(0, 3'b000, 0, 0, 32'd4, 32'd3, 32'd0, 32'h700, 0, 32'd7));
      @(posedge clk); #1;
      check("pre-reset MemWriteM", {31'd0, MemWriteM}, 32'd1);
      #1 reset = 1'b0;
      #1;
      check("async MemWriteM", {31'd0, MemWriteM}, 32'd0);
      check("async ALUResultM", ALUResultM, 32'd0);
      check("async RedirectCnt", RedirectCnt, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      drive(mk(0, 3'b011, 0, 0, 32'h0F, 32'hF0, 32'd0, 32'h800, 0, 32'hFF));
      @(posedge clk); #1;
      check("post-reset ALUResultM", ALUResultM, 32'hFF);
      check("post-reset PCPlus4M", PCPlus4M, 32'h804);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/iexecute.md
Name: iexecute

Overview:
- Execute stage of the 5-stage RV32I pipeline, directly downstream of the decode stage and its ID/EX register.
- Consumes the ID/EX outputs (control, operands, immediate, PCs) and applies forwarded operands.
- Computes the ALU result, branch/jump target and redirect (PCSrcE).
- Registers the memory-stage bundle into an internal EX/MEM pipeline register with stall and flush.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 32, width of the taken-redirect counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- StallM  in  1  hold EX/MEM register contents
- FlushM  in  1  load bubble into EX/MEM register
- RegWriteE  in  1  register write enable from ID/EX
- MemWriteE  in  1  memory write enable from ID/EX
- JumpE  in  1  jal/jalr instruction
- BranchE  in  1  beq instruction
- ALUSrcE  in  1  selects ALU source B: 0 = register operand, 1 = ImmExtE
- ResultSrcE  in  2  writeback select, passed through
- ALUControlE  in  3  ALU operation
- RdE  in  5  destination register
- RD1E, RD2E  in  XLEN  register operands
- PCE, ImmExtE, PCPlus4E  in  XLEN  from ID/EX
- ForwardAE, ForwardBE  in  2  operand forward select: 00 = RDxE, 01 = ResultW, 10 = ALUResultM, 11 = RDxE
- ResultW  in  XLEN  writeback-stage result
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  XLEN  PCE + ImmExtE (combinational)
- RegWriteM, MemWriteM  out  1  registered control
- ResultSrcM  out  2  registered control
- RdM  out  5  registered destination register
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN  registered data
- RedirectCnt  out  CNT_W  count of taken redirects

Behaviour:
- Operand select:
  - SrcAE = mux(ForwardAE: RD1E, ResultW, ALUResultM).
  - WriteDataE = mux(ForwardBE: RD2E, ResultW, ALUResultM).
  - SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU, all XLEN-bit with modulo wrap:
  - 000 add, 001 sub, 010 and, 011 or.
  - 101 slt: signed compare, result 1 or 0, zero-extended.
  - All other codes give result 0.
  - ZeroE = (ALU result == 0).
- Branch/jump:
  - PCTargetE = PCE + ImmExtE, wraps at 2^XLEN.
  - PCSrcE = JumpE | (BranchE & ZeroE), combinational in the same cycle.
- EX/MEM register, one-cycle latency:
  - On reset (async assert, low): all M outputs = 0 and RedirectCnt = 0.
  - Priority on the clock edge: FlushM > StallM > load.
  - Flush: RegWriteM = MemWriteM = 0; all other M fields = 0.
  - Stall: all M fields hold.
  - Load: captures RegWriteE, MemWriteE, ResultSrcE, RdE, ALU result, WriteDataE, PCPlus4E.
  - FlushM and StallM together: flush wins.
- Forward path 10 uses the currently registered ALUResultM, i.e. the instruction one ahead.
- RedirectCnt:
  - Increments by 1 each cycle PCSrcE = 1 and FlushM = 0; wraps at 2^CNT_W.
  - Unaffected by StallM.
- Reset deasserted mid-stream: first edge after release performs a normal load. No state other than the EX/MEM fields and the counter.

Optional Feature:
- Macro: IEXECUTE_FWD_EN.
- Defined: forwarding muxes as above.
- Undefined:
  - ForwardAE/ForwardBE are ignored; SrcAE = RD1E, WriteDataE = RD2E.
  - Hazards are left to stall logic upstream.
  - Ports remain present for interface compatibility.

Decomposition:
- Package riscv_pkg:
  - ALU opcode constants (ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101).
  - Forward select constants (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
  - XLEN default.
- One sub-module: alu (SrcA, SrcB, ALUControl -> ALUResult, Zero), purely combinational.
- EX/MEM register is written inline.

Test Plan:
- Add/sub:
  - RD1E=5, RD2E=3, ALUSrcE=0, ALUControlE=000 -> ALUResultM=8 one edge later.
  - ALUControlE=001 -> ALUResultM=2.
- SLT signed: RD1E=32'hFFFF_FFFF (-1), ImmExtE=1, ALUSrcE=1, ALUControlE=101 -> ALUResultM=1.
- Branch taken:
  - BranchE=1, RD1E=RD2E=7, ALUControlE=001, PCE=32'h100, ImmExtE=32'hFFFF_FFF0 -> PCSrcE=1 and PCTargetE=32'hF0 in the same cycle; RedirectCnt 0 -> 1.
  - RD2E=8 -> PCSrcE=0.
- Forwarding (IEXECUTE_FWD_EN defined): ALUResultM=32'h20, ResultW=32'h30, ForwardAE=10, ForwardBE=01, add -> next ALUResultM=32'h50 and WriteDataM=32'h30.
  - With the macro undefined, the same stimulus gives RD1E+RD2E.
- Stall/flush:
  - StallM=1 for 2 cycles -> M outputs unchanged.
  - FlushM=1 together with StallM=1 -> RegWriteM=MemWriteM=0 and RdM=0.
- Async reset:
  - Drive reset low mid-cycle with MemWriteM=1 -> all M outputs and RedirectCnt read 0 immediately, before the next clock.
  - Release reset -> normal load on the first edge.
